// File: rtl/dec10b8b.sv
// 10b/8b decoder: 5b/6b + 3b/4b table decode, K detection, running-disparity check.
// Optional saturating error counter on err_cnt when DEC10B8B_ERRCNT_EN is defined.
module dec10b8b #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [9:0] data_in,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd_out,
    output logic [7:0] err_cnt
);
    logic [5:0] s6;
    logic [3:0] s4, s4_lk;
    logic [4:0] edcba;
    logic [2:0] hgf, n6, n4;
    logic       v6, v4, k28, kx, alt4, alt_ok;
    logic       k_d, cerr_d, derr_d, rd_mid, rd_d;
    logic [7:0] data_d;
    logic       valid_q, k_q, cerr_q, derr_q, rd_q;
    logic [7:0] data_q;

    // Sub-blocks in transmission order: abcdei and fghj, first bit in the MSB.
    assign s6 = {data_in[0], data_in[1], data_in[2], data_in[3], data_in[4], data_in[5]};
    assign s4 = {data_in[6], data_in[7], data_in[8], data_in[9]};
    assign n6 = 3'($countones(s6));
    assign n4 = 3'($countones(s4));

    always_comb begin
        v6    = 1'b1;
        edcba = 5'd0;
        case (s6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110, 6'b001111, 6'b110000: edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            default:              v6 = 1'b0;
        endcase
    end

    // K.28 in its RD+ form carries the whole group complemented, so its 4b is looked up inverted.
    assign s4_lk = (s6 == 6'b110000) ? ~s4 : s4;

    always_comb begin
        v4  = 1'b1;
        hgf = 3'd0;
        case (s4_lk)
            4'b1011, 4'b0100:                   hgf = 3'd0;
            4'b1001:                            hgf = 3'd1;
            4'b0101:                            hgf = 3'd2;
            4'b1100, 4'b0011:                   hgf = 3'd3;
            4'b1101, 4'b0010:                   hgf = 3'd4;
            4'b1010:                            hgf = 3'd5;
            4'b0110:                            hgf = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
            default:                            v4 = 1'b0;
        endcase
    end

    assign k28  = (s6 == 6'b001111) || (s6 == 6'b110000);
    assign kx   = (s6 == 6'b111010) || (s6 == 6'b000101) || (s6 == 6'b110110) || (s6 == 6'b001001) ||
                  (s6 == 6'b101110) || (s6 == 6'b010001) || (s6 == 6'b011110) || (s6 == 6'b100001);
    assign alt4 = (s4 == 4'b0111) || (s4 == 4'b1000);
    // Data alternate 7 only follows D.17/18/20 (0111) or D.11/13/14 (1000).
    assign alt_ok = ((s4 == 4'b0111) && ((s6 == 6'b100011) || (s6 == 6'b010011) || (s6 == 6'b001011))) ||
                    ((s4 == 4'b1000) && ((s6 == 6'b110100) || (s6 == 6'b101100) || (s6 == 6'b011100)));
    assign k_d    = (k28 && v4) || (kx && alt4);
    assign cerr_d = !v6 || !v4 || (alt4 && !k_d && !alt_ok);
    assign data_d = {hgf, edcba};

    always_comb begin
        derr_d = 1'b0;
        rd_mid = rd_q;
        case (n6)
            3'd0, 3'd1: rd_mid = 1'b0;
            3'd2: begin derr_d = !rd_q; rd_mid = 1'b0; end
            3'd3: derr_d = ((s6 == 6'b111000) && rd_q) || ((s6 == 6'b000111) && !rd_q);
            3'd4: begin derr_d = rd_q; rd_mid = 1'b1; end
            default: rd_mid = 1'b1;
        endcase
        rd_d = rd_mid;
        case (n4)
            3'd0: rd_d = 1'b0;
            3'd1: begin derr_d = derr_d | !rd_mid; rd_d = 1'b0; end
            3'd2: derr_d = derr_d | ((s4 == 4'b1100) && rd_mid) | ((s4 == 4'b0011) && !rd_mid);
            3'd3: begin derr_d = derr_d | rd_mid; rd_d = 1'b1; end
            default: rd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            k_q     <= 1'b0;
            cerr_q  <= 1'b0;
            derr_q  <= 1'b0;
            rd_q    <= RD_INIT;
        end else begin
            valid_q <= valid_in;
            cerr_q  <= valid_in & cerr_d;
            derr_q  <= valid_in & derr_d;
            if (valid_in) begin
                data_q <= data_d;
                k_q    <= k_d;
                rd_q   <= rd_d;
            end
        end
    end

`ifdef DEC10B8B_ERRCNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= 8'h00;
        else if (valid_in && (cerr_d || derr_d) && (cnt_q != 8'hFF))
            cnt_q <= cnt_q + 8'd1;
    end
    assign err_cnt = cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign k_out     = k_q;
    assign code_err  = cerr_q;
    assign disp_err  = derr_q;
    assign rd_out    = rd_q;
endmodule

// File: doc/dec10b8b.md
Name: dec10b8b

Overview:
- 10b/8b decoder: the receive-side counterpart of the 8b/10b encoder datapath (5b/6b, 3b/4b, and the disparity-control functions).
- Takes one 10-bit code group per valid cycle and returns the 8-bit data byte plus the K (control) flag.
- Tracks running disparity (RD) across code groups.
- Flags code violations and disparity errors.
- Output is registered, with 1-cycle latency.

Parameters:
- RD_INIT, 0, running disparity at reset (0 = RD-, 1 = RD+).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in holds a code group this cycle.
- data_in  input  10  code group {j,h,g,f,i,e,d,c,b,a}; a = bit 0, transmitted first.
- valid_out  output  1  registered copy of valid_in.
- data_out  output  8  decoded byte {H,G,F,E,D,C,B,A}.
- k_out  output  1  decoded symbol is a K code.
- code_err  output  1  code group is not in the 8b/10b table.
- disp_err  output  1  running disparity violation.
- rd_out  output  1  current running disparity (0 = RD-).
- err_cnt  output  8  error counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - valid_out, data_out, k_out, code_err, disp_err and err_cnt clear to 0.
  - rd_out = RD_INIT.
- Latency: code group sampled at posedge N when valid_in=1; results appear at posedge N, visible in cycle N+1.
- valid_in=0 cycle:
  - valid_out=0; code_err=0; disp_err=0.
  - data_out, k_out and RD hold.
- 6b sub-block (abcdei) decode, per the standard 5b/6b table, both RD columns accepted:
  - Yields EDCBA.
  - Not in the table → code_err=1 and EDCBA=0.
- 4b sub-block (fghj) decode, per the standard 3b/4b table:
  - Yields HGF.
  - Primary and alternate D.x.7 (1110/0001 and 0111/1000) both decode to HGF=111.
  - Not in the table → code_err=1 and HGF=0.
- K detection; k_out=1 when:
  - 6b is 001111 or 110000 (K.28) with any valid 4b; or
  - 6b is the K.23, K.27, K.29 or K.30 code and 4b is 0111 or 1000.
- K-specific code errors: alternate 4b (0111/1000) following a 6b for which the standard does not allow it, and not a K code → code_err=1.
- RD checking, sequential: the 6b sub-block is checked against the current RD, then the 4b sub-block against the RD that follows the 6b.
  - 4 ones in 6b (3 ones in 4b): require RD-, else disp_err=1; RD becomes +.
  - 2 ones in 6b (1 one in 4b): require RD+, else disp_err=1; RD becomes -.
  - Balanced sub-block: RD unchanged.
  - Balanced but RD-specific codes (111000 and 1100 require RD-; 000111 and 0011 require RD+) in the wrong RD → disp_err=1.
  - Unbalanced beyond ±2: code_err=1, disp_err not set by that sub-block, RD takes the sign of that sub-block's disparity.
- Error recovery: after any error, RD follows the received sub-block disparity (resynchronises); there is no sticky state.
- rd_out is RD after the registered group.
- Simultaneous code_err and disp_err are both reported.

Optional Feature:
- Macro: DEC10B8B_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each valid group with code_err or disp_err set (one increment per group).
  - Saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: err_cnt is tied to 8'h00 and no counter logic is instantiated.

Test Plan:
- Reset, then valid_in=1 with data_in=10'h0B9 (D.0.0, RD-) → next cycle: valid_out=1, data_out=8'h00, k_out=0, code_err=0, disp_err=0, rd_out=0.
- 10'h17C (K.28.5 RD-) then 10'h283 (K.28.5 RD+) → both data_out=8'hBC, k_out=1, no errors; rd_out=1 then 0.
- 10'h17C twice back-to-back from reset → second group: disp_err=1, code_err=0, data_out=8'hBC, rd_out=1.
- data_in=10'h000 → code_err=1, disp_err=0, rd_out=0; with DEC10B8B_ERRCNT_EN, err_cnt=1.
- 260 consecutive 10'h000 with DEC10B8B_ERRCNT_EN → err_cnt saturates at 8'hFF.
- Valid group, one idle cycle (valid_in=0), then reset asserted mid-stream → idle cycle holds data_out with flags 0; reset immediately forces all outputs to reset values and rd_out=RD_INIT.
